// File: rtl/shift_register_if.sv
// Bus bundle for shift_register: control, parallel data and complementary outputs.
// Clock and reset stay plain ports on the register itself.
interface shift_register_if #(
  parameter int unsigned WIDTH = 4
);
  logic             L;
  logic             RTL;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] nQ;

  modport master (
    output L,
    output RTL,
    output D,
    input  Q,
    input  nQ
  );

  modport slave (
    input  L,
    input  RTL,
    input  D,
    output Q,
    output nQ
  );
endinterface

// File: rtl/shift_register.sv
// Bidirectional shift register with synchronous reset, parallel load and complementary outputs.
// The serial input bit is taken from the edge of D on the side data enters from.
module shift_register #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            C,
  input  logic            R,
  shift_register_if.slave bus
);

  logic [WIDTH-1:0] q;

  // Priority is reset, then load, then shift; there is no hold mode.
  always_ff @(posedge C) begin
    if (R) begin
      q <= '0;
    end else if (bus.L) begin
      q <= bus.D;
    end else if (bus.RTL) begin
      q <= {q[WIDTH-2:0], bus.D[0]};
    end else begin
      q <= {bus.D[WIDTH-1], q[WIDTH-1:1]};
    end
  end

  assign bus.Q  = q;
  assign bus.nQ = ~q;

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: stimulus pushes hand-computed expected Q values,
// a monitor pops and compares Q and nQ on every falling clock edge.
module tb_shift_register;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst;

  shift_register_if #(.WIDTH(WIDTH)) bus ();

  shift_register #(.WIDTH(WIDTH)) dut (
    .C   (clk),
    .R   (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_id[$];
  int               n_tests = 0;
  int               n_fail  = 0;

  // Monitor: one expected value is pending after each edge; check it mid-cycle.
  initial begin
    logic [WIDTH-1:0] e;
    int               id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = exp_id.pop_front();
        n_tests++;
        if (bus.Q !== e) begin
          n_fail++;
          $display("FAIL vec%0d_Q: got %b, expected %b", id, bus.Q, e);
        end
        n_tests++;
        if (bus.nQ !== ~e) begin
          n_fail++;
          $display("FAIL vec%0d_nQ: got %b, expected %b", id, bus.nQ, ~e);
        end
      end
    end
  end

  int vec = 0;

  // Drive one operation for the next rising edge; optionally wiggle D after the edge
  // so the mid-cycle check proves inputs are only sampled at the edge.
  task automatic op(input logic r, input logic l, input logic rtl,
                    input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e,
                    input bit toggle);
    rst     = r;
    bus.L   = l;
    bus.RTL = rtl;
    bus.D   = d;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    exp_id.push_back(vec);
    vec++;
    if (toggle) begin
      bus.D = ~d;
      #1;
      bus.D = d ^ 4'b0101;
      bus.L = ~l;
      bus.RTL = ~rtl;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; bus.L = 1'b0; bus.RTL = 1'b0; bus.D = '0;
    @(negedge clk);

    // Reset, and reset beating load
    op(1, 0, 1, 4'b1111, 4'b0000, 0);
    op(1, 1, 1, 4'b1111, 4'b0000, 0);
    // Left shift, serial-in from D[0]
    op(0, 0, 1, 4'b1111, 4'b0001, 0);
    op(0, 0, 1, 4'b1110, 4'b0010, 0);
    op(0, 0, 1, 4'b1110, 4'b0100, 0);
    op(0, 0, 1, 4'b1111, 4'b1001, 0);
    // Parallel load ignores direction
    op(0, 1, 1, 4'b1011, 4'b1011, 0);
    op(0, 1, 0, 4'b1011, 4'b1011, 0);
    // Right shift, serial-in from D[3]
    op(0, 0, 0, 4'b0000, 4'b0101, 0);
    op(0, 0, 0, 4'b1111, 4'b1010, 0);
    op(0, 0, 0, 4'b0111, 4'b0101, 0);
    op(0, 0, 0, 4'b1111, 4'b1010, 0);
    // Mid-sequence reset, then direction change with no bubble
    op(1, 0, 0, 4'b1111, 4'b0000, 0);
    op(0, 0, 0, 4'b1000, 4'b1000, 0);
    op(0, 0, 1, 4'b0001, 4'b0001, 0);
    // MSB / LSB discard
    op(0, 1, 0, 4'b1000, 4'b1000, 0);
    op(0, 0, 1, 4'b0000, 4'b0000, 0);
    op(0, 1, 1, 4'b0001, 4'b0001, 0);
    op(0, 0, 0, 4'b0000, 4'b0000, 0);
    // Inputs wiggled between edges have no effect; shift directly after load
    op(0, 1, 0, 4'b0110, 4'b0110, 1);
    op(0, 0, 0, 4'b0111, 4'b0011, 1);
    // Non-serial D bits ignored during shift
    op(0, 0, 0, 4'b0110, 4'b0001, 0);
    op(0, 0, 1, 4'b1110, 4'b0010, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
